// File: rtl/prbs_4ask_sym_src.sv
`default_nettype none
// ============================================================================
// Module   : prbs_4ask_sym_src
// Purpose  : 4-ASK symbol source for the TX pulse-shaping filter. A 15-bit
//            Fibonacci PRBS (x^15+x^14+1) supplies 2 bits per symbol. Each bit
//            pair is mapped to one of four 1s17 levels. The output is a 4x
//            zero-stuffed sample stream on sam_clk_en. An optional
//            alternating +3/-3 preamble precedes the payload.
// Ports    : sys_clk    - system clock, all logic on posedge
//            reset_n    - asynchronous active-low reset
//            sam_clk_en - one-cycle sample strobe
//            sym_clk_en - one-cycle symbol strobe (coincident with sam_clk_en)
//            enable     - run request, sampled at symbol boundaries only
//            sample_out - zero-stuffed 1s17 sample to the TX filter
//            sym_out    - current 1s17 symbol level, held between symbols
//            bits_out   - PRBS bit pair {b1,b0} of the current symbol
//            sym_valid  - one-cycle pulse when a new symbol is loaded
//            state_out  - 00 IDLE, 01 PREAMBLE, 10 RUN
// Config   : GRAY_MAP_EN - when defined, bit pairs use Gray level mapping
// Revision : 1.0 - initial release
// ============================================================================
module prbs_4ask_sym_src #(
    parameter logic [14:0] LFSR_SEED = 15'h7FFF,
    parameter logic [7:0]  PRE_LEN   = 8'd16,
    parameter logic [17:0] LVL_P3    = 18'h18000,
    parameter logic [17:0] LVL_P1    = 18'h08000,
    parameter logic [17:0] LVL_N1    = 18'h38000,
    parameter logic [17:0] LVL_N3    = 18'h28000
) (
    input  logic        sys_clk,
    input  logic        reset_n,
    input  logic        sam_clk_en,
    input  logic        sym_clk_en,
    input  logic        enable,
    output logic [17:0] sample_out,
    output logic [17:0] sym_out,
    output logic [1:0]  bits_out,
    output logic        sym_valid,
    output logic [1:0]  state_out
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_PRE  = 2'b01,
        ST_RUN  = 2'b10
    } state_t;

    state_t      state_q,   state_d;
    state_t      nxt_state;
    logic [14:0] lfsr_q,    lfsr_d;
    logic [7:0]  pre_cnt_q, pre_cnt_d;
    logic [17:0] sym_q,     sym_d;
    logic [1:0]  bits_q,    bits_d;
    logic        valid_q,   valid_d;
    logic [17:0] sample_q,  sample_d;

    // Two LFSR shifts per symbol, unrolled so the pair is ready in one cycle.
    logic        w_fb1, w_fb0;
    logic [14:0] w_s1, w_s2, w_lfsr_adv;
    logic [1:0]  w_pair;

    assign w_fb1      = lfsr_q[14] ^ lfsr_q[13];
    assign w_s1       = {lfsr_q[13:0], w_fb1};
    assign w_fb0      = w_s1[14] ^ w_s1[13];
    assign w_s2       = {w_s1[13:0], w_fb0};
    // The all-zero state would lock the generator forever; fall back to the seed.
    assign w_lfsr_adv = (w_s2 == 15'h0000) ? LFSR_SEED : w_s2;
    assign w_pair     = {w_fb1, w_fb0};

    function automatic logic [17:0] map_level(input logic [1:0] pair);
        logic [17:0] lvl;
        lvl = LVL_N3;
        case (pair)
`ifdef GRAY_MAP_EN
            2'b00:   lvl = LVL_N3;
            2'b01:   lvl = LVL_N1;
            2'b11:   lvl = LVL_P1;
            2'b10:   lvl = LVL_P3;
`else
            2'b00:   lvl = LVL_N3;
            2'b01:   lvl = LVL_N1;
            2'b10:   lvl = LVL_P1;
            2'b11:   lvl = LVL_P3;
`endif
            default: lvl = LVL_N3;
        endcase
        return lvl;
    endfunction

    // Next-state selection; only meaningful on a symbol strobe.
    always_comb begin
        nxt_state = state_q;
        case (state_q)
            ST_IDLE: begin
                if (enable) begin
                    nxt_state = (PRE_LEN != 8'd0) ? ST_PRE : ST_RUN;
                end
            end
            ST_PRE: begin
                if (!enable) begin
                    nxt_state = ST_IDLE;
                end else if (pre_cnt_q == PRE_LEN) begin
                    nxt_state = ST_RUN;
                end else begin
                    nxt_state = ST_PRE;
                end
            end
            ST_RUN: begin
                nxt_state = enable ? ST_RUN : ST_IDLE;
            end
            default: nxt_state = ST_IDLE;
        endcase
    end

    // Symbol load for the state being entered, plus zero stuffing.
    always_comb begin
        state_d   = state_q;
        lfsr_d    = lfsr_q;
        pre_cnt_d = pre_cnt_q;
        sym_d     = sym_q;
        bits_d    = bits_q;
        valid_d   = 1'b0;
        sample_d  = sample_q;

        if (sym_clk_en) begin
            state_d = nxt_state;
            case (nxt_state)
                ST_PRE: begin
                    // Even preamble index -> +3, odd -> -3.
                    sym_d     = pre_cnt_q[0] ? LVL_N3 : LVL_P3;
                    bits_d    = 2'b00;
                    valid_d   = 1'b1;
                    pre_cnt_d = pre_cnt_q + 8'd1;
                end
                ST_RUN: begin
                    lfsr_d    = w_lfsr_adv;
                    sym_d     = map_level(w_pair);
                    bits_d    = w_pair;
                    valid_d   = 1'b1;
                end
                default: begin
                    // IDLE: LFSR keeps its value so a re-enable resumes the sequence.
                    sym_d     = 18'h00000;
                    bits_d    = 2'b00;
                    pre_cnt_d = 8'd0;
                end
            endcase
        end

        if (sam_clk_en) begin
            sample_d = sym_clk_en ? sym_d : 18'h00000;
        end
    end

    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            lfsr_q    <= LFSR_SEED;
            pre_cnt_q <= 8'd0;
            sym_q     <= 18'h00000;
            bits_q    <= 2'b00;
            valid_q   <= 1'b0;
            sample_q  <= 18'h00000;
        end else begin
            state_q   <= state_d;
            lfsr_q    <= lfsr_d;
            pre_cnt_q <= pre_cnt_d;
            sym_q     <= sym_d;
            bits_q    <= bits_d;
            valid_q   <= valid_d;
            sample_q  <= sample_d;
        end
    end

    assign sample_out = sample_q;
    assign sym_out    = sym_q;
    assign bits_out   = bits_q;
    assign sym_valid  = valid_q;
    assign state_out  = state_q;

endmodule
`default_nettype wire

// File: tb/tb_prbs_4ask_sym_src.sv
`default_nettype none
// ============================================================================
// Module   : tb_prbs_4ask_sym_src
// Purpose  : Scoreboard bench for prbs_4ask_sym_src (PRE_LEN = 4). The driver
//            issues sample/symbol strobes and queues expected samples and
//            symbols; a monitor pops and compares when the DUT presents them.
// Revision : 1.0 - initial release
// ============================================================================
module tb_prbs_4ask_sym_src;

    localparam logic [14:0] C_SEED = 15'h7FFF;
    localparam logic [17:0] C_P3   = 18'h18000;
    localparam logic [17:0] C_P1   = 18'h08000;
    localparam logic [17:0] C_N1   = 18'h38000;
    localparam logic [17:0] C_N3   = 18'h28000;

    logic        sys_clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        sam_clk_en = 1'b0;
    logic        sym_clk_en = 1'b0;
    logic        enable = 1'b0;
    logic [17:0] sample_out;
    logic [17:0] sym_out;
    logic [1:0]  bits_out;
    logic        sym_valid;
    logic [1:0]  state_out;

    int n_total = 0;
    int n_pass  = 0;

    logic [17:0] sam_q[$];
    logic [21:0] sym_q[$];   // {state, bits, level}
    logic        sam_seen = 1'b0;
    logic [14:0] m_lfsr = C_SEED;

    prbs_4ask_sym_src #(
        .LFSR_SEED (C_SEED),
        .PRE_LEN   (8'd4),
        .LVL_P3    (C_P3),
        .LVL_P1    (C_P1),
        .LVL_N1    (C_N1),
        .LVL_N3    (C_N3)
    ) dut (
        .sys_clk    (sys_clk),
        .reset_n    (reset_n),
        .sam_clk_en (sam_clk_en),
        .sym_clk_en (sym_clk_en),
        .enable     (enable),
        .sample_out (sample_out),
        .sym_out    (sym_out),
        .bits_out   (bits_out),
        .sym_valid  (sym_valid),
        .state_out  (state_out)
    );

    always #20 sys_clk = ~sys_clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    endtask

    function automatic logic [17:0] lvl_of(input logic [1:0] p);
`ifdef GRAY_MAP_EN
        case (p)
            2'b00:   return C_N3;
            2'b01:   return C_N1;
            2'b11:   return C_P1;
            default: return C_P3;
        endcase
`else
        case (p)
            2'b00:   return C_N3;
            2'b01:   return C_N1;
            2'b10:   return C_P1;
            default: return C_P3;
        endcase
`endif
    endfunction

    // Bit-serial reference generator.
    task automatic model_pair(output logic [1:0] p);
        logic b;
        for (int i = 0; i < 2; i++) begin
            b      = m_lfsr[14] ^ m_lfsr[13];
            m_lfsr = {m_lfsr[13:0], b};
            p[1-i] = b;
        end
        if (m_lfsr == 15'h0) m_lfsr = C_SEED;
    endtask

    // Monitor: samples away from the active edge.
    always @(posedge sys_clk) sam_seen <= sam_clk_en;

    always @(negedge sys_clk) begin
        if (sam_seen && reset_n) begin
            if (sam_q.size() == 0) chk("sample_unexpected", 32'(sample_out), 32'hFFFF_FFFF);
            else chk("sample_out", 32'(sample_out), 32'(sam_q.pop_front()));
        end
        if (sym_valid) begin
            if (sym_q.size() == 0) chk("sym_valid_unexpected", 32'(sym_valid), 32'h0);
            else chk("symbol", 32'({state_out, bits_out, sym_out}), 32'(sym_q.pop_front()));
        end
    end

    task automatic wait_cycles(input int n);
        repeat (n) begin
            @(posedge sys_clk);
            #1;
        end
    endtask

    task automatic strobe(input logic sym);
        sam_clk_en = 1'b1;
        sym_clk_en = sym;
        @(posedge sys_clk);
        #1;
        sam_clk_en = 1'b0;
        sym_clk_en = 1'b0;
    endtask

    // One full symbol period: boundary sample plus three stuffed zeros.
    task automatic sym_step(input logic en, input logic glitch, input logic [1:0] st_exp,
                            input logic v_exp, input logic [17:0] s_exp, input logic [1:0] b_exp);
        enable = en;
        sam_q.push_back(s_exp);
        if (v_exp) sym_q.push_back({st_exp, b_exp, s_exp});
        strobe(1'b1);
        chk("state_out", 32'(state_out), 32'(st_exp));
        if (!v_exp) begin
            chk("idle_sym_out", 32'(sym_out), 32'h0);
            chk("idle_bits_out", 32'(bits_out), 32'h0);
        end
        if (glitch) enable = 1'b0;
        wait_cycles(3);
        for (int k = 0; k < 3; k++) begin
            sam_q.push_back(18'h0);
            strobe(1'b0);
            wait_cycles(3);
        end
        if (glitch) begin
            chk("glitch_state", 32'(state_out), 32'(st_exp));
            enable = en;
        end
    endtask

    task automatic run_sym(input logic glitch);
        logic [1:0] p;
        model_pair(p);
        sym_step(1'b1, glitch, 2'b10, 1'b1, lvl_of(p), p);
    endtask

    // First RUN symbols from the 7FFF seed are hand-derived: pairs 00 -> N3.
    task automatic run_first4;
        logic [1:0] p;
        for (int i = 0; i < 4; i++) begin
            model_pair(p);
            sym_step(1'b1, 1'b0, 2'b10, 1'b1, C_N3, 2'b00);
        end
    endtask

    task automatic preamble4;
        sym_step(1'b1, 1'b0, 2'b01, 1'b1, C_P3, 2'b00);
        sym_step(1'b1, 1'b0, 2'b01, 1'b1, C_N3, 2'b00);
        sym_step(1'b1, 1'b0, 2'b01, 1'b1, C_P3, 2'b00);
        sym_step(1'b1, 1'b0, 2'b01, 1'b1, C_N3, 2'b00);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset held with enable high.
        reset_n = 1'b0;
        enable  = 1'b1;
        wait_cycles(3);
        chk("rst_state", 32'(state_out), 32'h0);
        chk("rst_sample", 32'(sample_out), 32'h0);
        chk("rst_sym", 32'(sym_out), 32'h0);
        chk("rst_bits", 32'(bits_out), 32'h0);
        chk("rst_valid", 32'(sym_valid), 32'h0);
        reset_n = 1'b1;
        wait_cycles(2);

        preamble4();
        run_first4();
        for (int i = 0; i < 40; i++) run_sym(1'b0);

        // Enable toggled between boundaries must not disturb RUN.
        run_sym(1'b1);
        run_sym(1'b0);

        // Enable low across a boundary -> IDLE, zero symbol.
        sym_step(1'b0, 1'b0, 2'b00, 1'b0, 18'h0, 2'b00);
        sym_step(1'b0, 1'b0, 2'b00, 1'b0, 18'h0, 2'b00);

        // Re-enable: preamble restarts, PRBS resumes from the held state.
        preamble4();
        for (int i = 0; i < 200; i++) run_sym(1'b0);

        // Asynchronous reset between strobes.
        begin
            logic [1:0] p;
            model_pair(p);
            enable = 1'b1;
            sam_q.push_back(lvl_of(p));
            sym_q.push_back({2'b10, p, lvl_of(p)});
            strobe(1'b1);
            wait_cycles(1);
            reset_n = 1'b0;
            #1;
            chk("arst_state", 32'(state_out), 32'h0);
            chk("arst_sample", 32'(sample_out), 32'h0);
            chk("arst_sym", 32'(sym_out), 32'h0);
            chk("arst_bits", 32'(bits_out), 32'h0);
            chk("arst_valid", 32'(sym_valid), 32'h0);
            m_lfsr = C_SEED;
            wait_cycles(3);
            reset_n = 1'b1;
            wait_cycles(2);
        end

        // After reset the sequence restarts from the seed.
        preamble4();
        run_first4();
        for (int i = 0; i < 8; i++) run_sym(1'b0);

        enable = 1'b0;
        wait_cycles(4);
        chk("sam_queue_drained", 32'(sam_q.size()), 32'h0);
        chk("sym_queue_drained", 32'(sym_q.size()), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
